// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and element indexing for the matrix unit.
package matrix_pkg;

    localparam int MAX_DIM = 5;
    localparam int ELEM_W  = 16;
    localparam int DIM_W   = 3;
    localparam int SRC_W   = MAX_DIM * MAX_DIM * 8;       // packed 8-bit source matrix
    localparam int PROD_W  = MAX_DIM * MAX_DIM * ELEM_W;  // packed 16-bit product matrix
    localparam int IDX_W   = $clog2(MAX_DIM * MAX_DIM);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Flat row-major slot of element (r,c) inside the packed product.
    function automatic logic [IDX_W-1:0] elem_idx(input logic [DIM_W-1:0] r,
                                                  input logic [DIM_W-1:0] c);
        return IDX_W'(r) * IDX_W'(MAX_DIM) + IDX_W'(c);
    endfunction

endpackage

// File: rtl/matrix_rc_counter.sv
// Row/column walker over an m x n matrix. Holds its own copy of the bounds
// and keeps eol/last registered so they line up with the indices.
module matrix_rc_counter #(
    parameter int DIM_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [DIM_W-1:0] m,
    input  logic [DIM_W-1:0] n,
    output logic [DIM_W-1:0] row,
    output logic [DIM_W-1:0] col,
    output logic [DIM_W-1:0] next_row,
    output logic [DIM_W-1:0] next_col,
    output logic             eol,
    output logic             last
);

    logic [DIM_W-1:0] row_r, col_r, m_r, n_r;
    logic             eol_r, last_r;
    logic [DIM_W-1:0] next_row_s, next_col_s;
    logic             next_eol_s, next_last_s;

    // Position the walk reaches after one more element, with its end flags.
    always_comb begin
        if (col_r == n_r - DIM_W'(1)) begin
            next_col_s = DIM_W'(0);
            next_row_s = row_r + DIM_W'(1);
        end else begin
            next_col_s = col_r + DIM_W'(1);
            next_row_s = row_r;
        end
        next_eol_s  = (next_col_s == n_r - DIM_W'(1));
        next_last_s = next_eol_s && (next_row_s == m_r - DIM_W'(1));
    end

    // Load restarts at (0,0) with fresh bounds; advance steps one element.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_r  <= DIM_W'(0);
            col_r  <= DIM_W'(0);
            m_r    <= DIM_W'(0);
            n_r    <= DIM_W'(0);
            eol_r  <= 1'b0;
            last_r <= 1'b0;
        end else if (load) begin
            row_r  <= DIM_W'(0);
            col_r  <= DIM_W'(0);
            m_r    <= m;
            n_r    <= n;
            eol_r  <= (n == DIM_W'(1));
            last_r <= (n == DIM_W'(1)) && (m == DIM_W'(1));
        end else if (advance) begin
            row_r  <= next_row_s;
            col_r  <= next_col_s;
            eol_r  <= next_eol_s;
            last_r <= next_last_s;
        end else begin
            row_r  <= row_r;
            col_r  <= col_r;
        end
    end

    assign row      = row_r;
    assign col      = col_r;
    assign next_row = next_row_s;
    assign next_col = next_col_s;
    assign eol      = eol_r;
    assign last     = last_r;

endmodule

// File: rtl/matrix_result_streamer.sv
// Captures a packed product matrix on start and streams it row-major over
// a valid/ready port. All outputs come straight from registers.
module matrix_result_streamer #(
    parameter int MAX_DIM = matrix_pkg::MAX_DIM,
    parameter int ELEM_W  = matrix_pkg::ELEM_W,
    parameter int DIM_W   = matrix_pkg::DIM_W
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic [DIM_W-1:0]                    c_m,
    input  logic [DIM_W-1:0]                    c_n,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   aMulB,
    input  logic                                valid,
    input  logic                                mulError,
    input  logic                                abort,
    output logic                                busy,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [ELEM_W-1:0]                   out_data,
    output logic [DIM_W-1:0]                    out_row,
    output logic [DIM_W-1:0]                    out_col,
    output logic                                out_eol,
    output logic                                out_last,
    output logic                                done,
    output logic                                err
);

    import matrix_pkg::*;

    state_t              state_r;
    logic [ELEM_W-1:0]   elems_r [MAX_DIM*MAX_DIM];
    logic [ELEM_W-1:0]   out_data_r;
    logic                out_valid_r, busy_r, done_r, err_r;
    logic                start_ok_s, load_s, transfer_s, advance_s;
    logic [DIM_W-1:0]    next_row_s, next_col_s;
    logic [IDX_W-1:0]    next_idx_s;

    // Decode start acceptance and the output handshake.
    always_comb begin
        start_ok_s = start && valid && !mulError
                  && (c_m != DIM_W'(0)) && (c_m <= DIM_W'(MAX_DIM))
                  && (c_n != DIM_W'(0)) && (c_n <= DIM_W'(MAX_DIM));
        load_s     = (state_r == ST_IDLE) && start_ok_s;
        transfer_s = (state_r == ST_STREAM) && out_valid_r && out_ready;
        advance_s  = transfer_s && !abort;
        next_idx_s = elem_idx(next_row_s, next_col_s);
    end

    matrix_rc_counter #(.DIM_W(DIM_W)) u_rc (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .advance  (advance_s),
        .m        (c_m),
        .n        (c_n),
        .row      (out_row),
        .col      (out_col),
        .next_row (next_row_s),
        .next_col (next_col_s),
        .eol      (out_eol),
        .last     (out_last)
    );

    // Stream controller: capture, element selection and status pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            out_data_r  <= ELEM_W'(0);
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            for (int i = 0; i < MAX_DIM*MAX_DIM; i++) begin
                elems_r[i] <= ELEM_W'(0);
            end
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (load_s) begin
                        for (int i = 0; i < MAX_DIM*MAX_DIM; i++) begin
                            elems_r[i] <= aMulB[i*ELEM_W +: ELEM_W];
                        end
                        // Element (0,0) sits in the lowest slot of the input.
                        out_data_r  <= aMulB[ELEM_W-1:0];
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= ST_STREAM;
                    end else if (start) begin
                        err_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else if (transfer_s && out_last) begin
                        out_valid_r <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= ST_DONE;
                    end else if (transfer_s) begin
                        out_data_r <= elems_r[next_idx_s];
                    end else begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_DONE: begin
                    // busy stays up through the done cycle and drops with it.
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed and randomized checks of matrix_result_streamer against a
// matrix-multiply reference model held in the bench.
module tb_matrix_result_streamer;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   c_m = 3'd0;
    logic [2:0]   c_n = 3'd0;
    logic [399:0] aMulB = 400'd0;
    logic         valid = 1'b0;
    logic         mulError = 1'b0;
    logic         abort = 1'b0;
    logic         busy;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [15:0]  out_data;
    logic [2:0]   out_row;
    logic [2:0]   out_col;
    logic         out_eol;
    logic         out_last;
    logic         done;
    logic         err;

    int checks = 0;
    int errors = 0;

    int          a_m [5][5];
    int          b_m [5][5];
    logic [15:0] exp_e [25];

    matrix_result_streamer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .c_m       (c_m),
        .c_n       (c_n),
        .aMulB     (aMulB),
        .valid     (valid),
        .mulError  (mulError),
        .abort     (abort),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_eol   (out_eol),
        .out_last  (out_last),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference product C = A(m x kk) * B(kk x n), truncated to 16 bits.
    task automatic build_product(input int m, input int kk, input int n);
        for (int r = 0; r < m; r++) begin
            for (int c = 0; c < n; c++) begin
                int sum = 0;
                for (int t = 0; t < kk; t++) sum += a_m[r][t] * b_m[t][c];
                exp_e[r*n+c] = sum[15:0];
            end
        end
    endtask

    // Pack expected elements at stride 5, with junk in unused slots.
    task automatic pack_matrix(input int m, input int n);
        for (int i = 0; i < 25; i++) aMulB[i*16 +: 16] = 16'($urandom);
        for (int r = 0; r < m; r++)
            for (int c = 0; c < n; c++)
                aMulB[(r*5+c)*16 +: 16] = exp_e[r*n+c];
    endtask

    // Start a stream and consume it. mode 0: ready=1, 1: 1,0,0,1 pattern,
    // 2: random. abort_at<0 means no abort; disturb alters inputs mid-stream.
    task automatic run_stream(input int m, input int n, input int mode,
                              input int abort_at, input bit disturb);
        int k = 0;
        int cyc = 0;
        int total = m * n;
        bit r;
        c_m = 3'(m); c_n = 3'(n); valid = 1'b1; mulError = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (k < total && cyc < 400) begin
            chk("valid", out_valid, 1);
            chk("busy", busy, 1);
            chk("no_done", done, 0);
            chk("no_err", err, 0);
            chk("data", out_data, exp_e[k]);
            chk("row", out_row, k / n);
            chk("col", out_col, k % n);
            chk("eol", out_eol, (k % n) == n - 1);
            chk("last", out_last, k == total - 1);
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: r = 1'(($urandom));
            endcase
            out_ready = r;
            if (k == abort_at) abort = 1'b1;
            if (disturb && cyc == 1) begin
                for (int i = 0; i < 25; i++) aMulB[i*16 +: 16] = 16'($urandom);
                start = 1'b1;
            end
            step();
            start = 1'b0;
            if (abort) begin
                abort = 1'b0;
                chk("abort_valid", out_valid, 0);
                chk("abort_busy", busy, 0);
                chk("abort_done", done, 0);
                step();
                chk("abort_done2", done, 0);
                chk("abort_valid2", out_valid, 0);
                return;
            end
            if (r) k++;
            cyc++;
        end
        chk("stream_complete", k, total);
        chk("done_pulse", done, 1);
        chk("done_valid", out_valid, 0);
        chk("done_busy", busy, 1);
        step();
        chk("done_clear", done, 0);
        chk("busy_clear", busy, 0);
        chk("idle_valid", out_valid, 0);
    endtask

    task automatic reject_case(input int m, input int n, input bit v, input bit me);
        c_m = 3'(m); c_n = 3'(n); valid = v; mulError = me;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rej_err", err, 1);
        chk("rej_busy", busy, 0);
        chk("rej_valid", out_valid, 0);
        step();
        chk("rej_err_clear", err, 0);
        chk("rej_valid2", out_valid, 0);
        chk("rej_busy2", busy, 0);
    endtask

    task automatic load_directed();
        int av [2][3] = '{'{1, 2, 3}, '{3, 4, 5}};
        int bv [3][2] = '{'{1, 0}, '{2, 1}, '{3, 2}};
        for (int r = 0; r < 2; r++) for (int t = 0; t < 3; t++) a_m[r][t] = av[r][t];
        for (int t = 0; t < 3; t++) for (int c = 0; c < 2; c++) b_m[t][c] = bv[t][c];
        build_product(2, 3, 2);
        pack_matrix(2, 2);
    endtask

    initial begin
        // Reset values, held and after release.
        #23;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_last", out_last, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("post_rst_valid", out_valid, 0);
        chk("post_rst_row", out_row, 0);

        // 2x3 * 3x2 product: 14, 8, 26, 14.
        load_directed();
        chk("model_c00", exp_e[0], 14);
        chk("model_c11", exp_e[3], 14);
        run_stream(2, 2, 0, -1, 1'b0);

        // Same product under backpressure.
        load_directed();
        run_stream(2, 2, 1, -1, 1'b0);

        // Rejected starts.
        reject_case(2, 2, 1'b1, 1'b1);
        reject_case(0, 2, 1'b1, 1'b0);
        reject_case(2, 6, 1'b1, 1'b0);
        reject_case(2, 2, 1'b0, 1'b0);

        // 5x5 ramp with inputs disturbed mid-stream.
        for (int i = 0; i < 25; i++) exp_e[i] = 16'(i);
        pack_matrix(5, 5);
        run_stream(5, 5, 0, -1, 1'b1);

        // 1x1 matrix.
        exp_e[0] = 16'hBEEF;
        pack_matrix(1, 1);
        run_stream(1, 1, 0, -1, 1'b0);

        // Abort after the second transfer, then abort on the final transfer.
        load_directed();
        run_stream(2, 2, 0, 2, 1'b0);
        load_directed();
        run_stream(2, 2, 0, 3, 1'b0);

        // Reset asserted mid-stream clears outputs immediately.
        for (int i = 0; i < 25; i++) exp_e[i] = 16'(i + 100);
        pack_matrix(5, 5);
        c_m = 3'd5; c_n = 3'd5; valid = 1'b1; mulError = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_data", out_data, 0);
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("arst_no_resume", out_valid, 0);
        load_directed();
        run_stream(2, 2, 0, -1, 1'b0);

        // Random products with random backpressure.
        for (int it = 0; it < 6; it++) begin
            int m  = int'($urandom_range(1, 5));
            int kk = int'($urandom_range(1, 5));
            int n  = int'($urandom_range(1, 5));
            for (int r = 0; r < 5; r++)
                for (int c = 0; c < 5; c++) begin
                    a_m[r][c] = int'($urandom_range(0, 255));
                    b_m[r][c] = int'($urandom_range(0, 255));
                end
            build_product(m, kk, n);
            pack_matrix(m, n);
            run_stream(m, n, 2, -1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
